// File: rtl/overlay_pkg.sv
// Shared types and defaults for the overlay coordinate path.
package overlay_pkg;

  localparam int DEF_H_ACT    = 640;
  localparam int DEF_V_ACT    = 480;
  localparam int DEF_BOX_HALF = 10;

  typedef logic [9:0] coord_x_t;
  typedef logic [8:0] coord_y_t;

  typedef enum logic [1:0] {IDLE, HELD, COMMIT} ovl_state_t;

  typedef enum logic {SRC_HOST = 1'b0, SRC_TRK = 1'b1} src_t;

  typedef struct packed {
    coord_x_t x;
    coord_y_t y;
    src_t     src;
  } pend_t;

  // Unsigned saturating clamp; callers zero-extend so nothing wraps.
  function automatic logic [10:0] clampU(input logic [10:0] v,
                                         input logic [10:0] lo,
                                         input logic [10:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/overlay_frame_sync.sv
// Combinational end-of-active-frame strobe from the raster counters.
module overlay_frame_sync
  import overlay_pkg::*;
#(
  parameter int H_ACT = DEF_H_ACT,
  parameter int V_ACT = DEF_V_ACT
) (
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  input  logic        iDVAL,
  output logic        fe
);

  assign fe = iDVAL && (iX_Cont == 11'(H_ACT - 1)) && (iY_Cont == 11'(V_ACT - 1));

endmodule

// File: rtl/overlay_coord_ctrl.sv
// Two-requester overlay target arbiter: clamps, holds, and commits coordinates
// only at frame end so the marker never tears; stale targets time out.
module overlay_coord_ctrl
  import overlay_pkg::*;
#(
  parameter int H_ACT          = DEF_H_ACT,
  parameter int V_ACT          = DEF_V_ACT,
  parameter int BOX_HALF       = DEF_BOX_HALF,
  parameter int TIMEOUT_FRAMES = 30
) (
  input  logic           iCLK,
  input  logic           iRST,
  input  logic [10:0]    iX_Cont,
  input  logic [10:0]    iY_Cont,
  input  logic           iDVAL,
  input  logic           iReq0_valid,
  input  coord_x_t       iReq0_x,
  input  coord_y_t       iReq0_y,
  output logic           oReq0_ready,
  input  logic           iReq1_valid,
  input  coord_x_t       iReq1_x,
  input  coord_y_t       iReq1_y,
  output logic           oReq1_ready,
  output coord_x_t       driven_coordinates_x,
  output coord_y_t       driven_coordinates_y,
  output logic           oOverlay_en,
  output logic           oCommit,
  output logic           oSrc
);

  localparam logic [10:0] XLO = 11'(BOX_HALF);
  localparam logic [10:0] XHI = 11'(H_ACT - 1 - BOX_HALF);
  localparam logic [10:0] YLO = 11'(BOX_HALF);
  localparam logic [10:0] YHI = 11'(V_ACT - 1 - BOX_HALF);
  localparam int          TW  = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_FRAMES);

  logic          fe;
  ovl_state_t    state, stateNext;
  pend_t         pend, incoming, commitData;
  logic          rdy, acc0, acc1, anyAcc, hostPending, commitNow, toFire;
  coord_x_t      selX;
  coord_y_t      selY;
  logic [TW-1:0] toCnt, toCntNext;

  overlay_frame_sync #(.H_ACT(H_ACT), .V_ACT(V_ACT)) uFrameSync (
    .iX_Cont (iX_Cont),
    .iY_Cont (iY_Cont),
    .iDVAL   (iDVAL),
    .fe      (fe)
  );

  // rdy is registered from the next state, so it is low in reset and in COMMIT.
  assign hostPending = (state == HELD) && (pend.src == SRC_HOST);
  assign oReq0_ready = rdy;
  assign oReq1_ready = rdy && !iReq0_valid && !hostPending;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (anyAcc) stateNext = fe ? COMMIT : HELD;
      HELD:    if (fe)     stateNext = COMMIT;
      COMMIT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    acc0   = iReq0_valid && rdy;
    acc1   = iReq1_valid && oReq1_ready;
    anyAcc = acc0 || acc1;

    selX = acc0 ? iReq0_x : iReq1_x;
    selY = acc0 ? iReq0_y : iReq1_y;
    incoming.x   = coord_x_t'(clampU({1'b0, selX}, XLO, XHI));
    incoming.y   = coord_y_t'(clampU({2'b00, selY}, YLO, YHI));
    incoming.src = acc0 ? SRC_HOST : SRC_TRK;

    // An accept landing on the FE cycle is the newest value and wins.
    commitNow  = fe && ((state == HELD) || (state == IDLE && anyAcc));
    commitData = anyAcc ? incoming : pend;

    toCntNext = toCnt;
    if (commitNow)                toCntNext = '0;
    else if (fe && toCnt != TO_MAX) toCntNext = toCnt + 1'b1;
    toFire = (TIMEOUT_FRAMES != 0) && fe && !commitNow && (toCntNext == TO_MAX);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rdy                  <= 1'b0;
      pend                 <= '0;
      toCnt                <= '0;
      driven_coordinates_x <= coord_x_t'(H_ACT / 2);
      driven_coordinates_y <= coord_y_t'(V_ACT / 2);
      oOverlay_en          <= 1'b0;
      oCommit              <= 1'b0;
      oSrc                 <= 1'b0;
    end else begin
      rdy     <= (stateNext != COMMIT);
      toCnt   <= toCntNext;
      oCommit <= commitNow;
      if (anyAcc) pend <= incoming;
      if (commitNow) begin
        driven_coordinates_x <= commitData.x;
        driven_coordinates_y <= commitData.y;
        oSrc                 <= commitData.src;
        oOverlay_en          <= 1'b1;
      end else if (toFire) begin
        oOverlay_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_overlay_coord_ctrl.sv
// Directed bench for overlay_coord_ctrl with hand-computed expectations.
module tb_overlay_coord_ctrl;
  import overlay_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [10:0] iX_Cont, iY_Cont;
  logic        iDVAL;
  logic        iReq0_valid, iReq1_valid;
  coord_x_t    iReq0_x, iReq1_x;
  coord_y_t    iReq0_y, iReq1_y;
  logic        oReq0_ready, oReq1_ready;
  coord_x_t    driven_coordinates_x;
  coord_y_t    driven_coordinates_y;
  logic        oOverlay_en, oCommit, oSrc;

  int vecs = 0;
  int errs = 0;

  always #5 iCLK = ~iCLK;

  overlay_coord_ctrl #(.TIMEOUT_FRAMES(3)) dut (
    .iCLK                 (iCLK),
    .iRST                 (iRST),
    .iX_Cont              (iX_Cont),
    .iY_Cont              (iY_Cont),
    .iDVAL                (iDVAL),
    .iReq0_valid          (iReq0_valid),
    .iReq0_x              (iReq0_x),
    .iReq0_y              (iReq0_y),
    .oReq0_ready          (oReq0_ready),
    .iReq1_valid          (iReq1_valid),
    .iReq1_x              (iReq1_x),
    .iReq1_y              (iReq1_y),
    .oReq1_ready          (oReq1_ready),
    .driven_coordinates_x (driven_coordinates_x),
    .driven_coordinates_y (driven_coordinates_y),
    .oOverlay_en          (oOverlay_en),
    .oCommit              (oCommit),
    .oSrc                 (oSrc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic pix(input logic dv, input int x, input int y);
    iDVAL   = dv;
    iX_Cont = 11'(x);
    iY_Cont = 11'(y);
  endtask

  task automatic req0(input logic v, input int x, input int y);
    iReq0_valid = v;
    iReq0_x     = coord_x_t'(x);
    iReq0_y     = coord_y_t'(y);
  endtask

  task automatic req1(input logic v, input int x, input int y);
    iReq1_valid = v;
    iReq1_x     = coord_x_t'(x);
    iReq1_y     = coord_y_t'(y);
  endtask

  task automatic chkOut(input string tag, input int x, input int y,
                        input logic en, input logic cm, input logic src);
    chk({tag, ".x"},   32'(driven_coordinates_x), 32'(x));
    chk({tag, ".y"},   32'(driven_coordinates_y), 32'(y));
    chk({tag, ".en"},  32'(oOverlay_en), 32'(en));
    chk({tag, ".cm"},  32'(oCommit), 32'(cm));
    chk({tag, ".src"}, 32'(oSrc), 32'(src));
  endtask

  initial begin
    iRST = 1'b0;
    pix(0, 0, 0);
    req0(0, 0, 0);
    req1(0, 0, 0);
    repeat (3) step();
    chkOut("rst", 320, 240, 0, 0, 0);
    chk("rst.rdy0", 32'(oReq0_ready), 0);
    chk("rst.rdy1", 32'(oReq1_ready), 0);

    iRST = 1'b1;
    step();
    chk("rel.rdy0", 32'(oReq0_ready), 1);

    // host (700,500) saturates to (629,469)
    req0(1, 700, 500);
    step();
    req0(0, 0, 0);
    pix(1, 639, 478);
    step();
    chkOut("t1.pre", 320, 240, 0, 0, 0);
    pix(1, 639, 479);
    step();
    pix(0, 0, 0);
    chkOut("t1.fe", 629, 469, 1, 1, 0);
    chk("t1.rdyC", 32'(oReq0_ready), 0);
    step();
    chk("t1.cm1", 32'(oCommit), 0);
    chk("t1.rdyI", 32'(oReq0_ready), 1);

    // simultaneous requests: host wins, tracker locked out while host pends
    req0(1, 100, 50);
    req1(1, 200, 60);
    #1;
    chk("t2.rdy0", 32'(oReq0_ready), 1);
    chk("t2.rdy1", 32'(oReq1_ready), 0);
    step();
    req0(0, 0, 0);
    #1;
    chk("t2.held1", 32'(oReq1_ready), 0);
    step();
    chk("t2.held2", 32'(oReq1_ready), 0);
    chkOut("t2.pre", 629, 469, 1, 0, 0);
    pix(1, 639, 479);
    step();
    pix(0, 0, 0);
    chkOut("t2.fe", 100, 50, 1, 1, 0);
    chk("t2.rdy1C", 32'(oReq1_ready), 0);
    req1(0, 0, 0);
    step();
    chk("t2.rdy1I", 32'(oReq1_ready), 1);

    // two tracker accepts in one frame: latest wins
    req1(1, 50, 40);
    step();
    req1(1, 60, 45);
    #1;
    chk("t3.rdy1", 32'(oReq1_ready), 1);
    step();
    req1(0, 0, 0);
    chkOut("t3.pre", 100, 50, 1, 0, 0);
    pix(1, 639, 479);
    step();
    pix(0, 0, 0);
    chkOut("t3.fe", 60, 45, 1, 1, 1);
    step();

    // accept on the FE cycle itself, low-side x clamp
    req1(1, 5, 500);
    pix(1, 639, 479);
    step();
    req1(0, 0, 0);
    pix(0, 0, 0);
    chkOut("t4.fe", 10, 469, 1, 1, 1);
    chk("t4.rdyC", 32'(oReq0_ready), 0);
    step();
    chk("t4.rdyI", 32'(oReq0_ready), 1);
    chk("t4.cm1", 32'(oCommit), 0);

    // timeout after 3 idle FEs, then re-enable
    for (int i = 1; i <= 4; i++) begin
      pix(1, 639, 479);
      step();
      pix(0, 0, 0);
      chkOut($sformatf("t5.fe%0d", i), 10, 469, (i < 3), 0, 1);
      step();
    end
    req0(1, 400, 300);
    step();
    req0(0, 0, 0);
    chk("t5.pendEn", 32'(oOverlay_en), 0);
    pix(1, 639, 479);
    step();
    pix(0, 0, 0);
    chkOut("t5.re", 400, 300, 1, 1, 0);
    step();

    // reset while a host entry is pending
    req0(1, 300, 200);
    step();
    req0(0, 0, 0);
    #1;
    chk("t6.held", 32'(oReq1_ready), 0);
    iRST = 1'b0;
    #1;
    chkOut("t6.rst", 320, 240, 0, 0, 0);
    chk("t6.rdy0", 32'(oReq0_ready), 0);
    step();
    iRST = 1'b1;
    step();
    pix(1, 639, 479);
    step();
    pix(0, 0, 0);
    chkOut("t6.fe", 320, 240, 0, 0, 0);
    chk("t6.rdy", 32'(oReq0_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/overlay_coord_ctrl.md
# overlay_coord_ctrl

Arbitrates overlay-target coordinate updates from two requesters: a host/command path and the auto-tracker. Clamps accepted coordinates so the full overlay box stays inside the 640x480 frame. Commits updates only at the end of the active frame, so the marker never tears mid-frame. Drives `driven_coordinates_x/y` and an overlay enable into the RAW2RGB overlay stage, and ages out stale targets.

## Interface
Parameters:
- `H_ACT`, 640, active pixels per line
- `V_ACT`, 480, active lines per frame
- `BOX_HALF`, 10, overlay half-width in pixels, used for clamping
- `TIMEOUT_FRAMES`, 30, frames without a commit before the overlay disables; 0 disables the timeout

Ports:
- `iCLK`  in  1  pixel clock; single clock domain
- `iRST`  in  1  reset, asynchronous, active-low
- `iX_Cont`  in  11  pixel column of the current `iDATA`
- `iY_Cont`  in  11  pixel row of the current `iDATA`
- `iDVAL`  in  1  pixel valid
- `iReq0_valid`  in  1  host request (priority requester)
- `iReq0_x` / `iReq0_y`  in  10 / 9  host target coordinates
- `oReq0_ready`  out  1  host handshake ready
- `iReq1_valid`  in  1  tracker request
- `iReq1_x` / `iReq1_y`  in  10 / 9  tracker target coordinates
- `oReq1_ready`  out  1  tracker handshake ready
- `driven_coordinates_x`  out  10  committed overlay centre X
- `driven_coordinates_y`  out  9  committed overlay centre Y
- `oOverlay_en`  out  1  overlay active
- `oCommit`  out  1  one-cycle pulse when new coordinates take effect
- `oSrc`  out  1  source of the last commit (0 = host, 1 = tracker)

## Operation
- Frame end (FE): a cycle with `iDVAL`=1, `iX_Cont`=H_ACT-1 and `iY_Cont`=V_ACT-1.
- FSM states:
  - IDLE: nothing pending.
  - HELD: a pending coordinate is latched.
  - COMMIT: one cycle.
- Transitions:
  - IDLE→HELD on any accept.
  - HELD→COMMIT on FE.
  - IDLE→COMMIT on FE with a same-cycle accept.
  - COMMIT→IDLE unconditionally.
  - IDLE on FE with no accept: stays IDLE; the timeout counter increments.
- Handshake:
  - Accept = valid & ready.
  - `oReq0_ready` is 1 in IDLE/HELD and 0 in COMMIT and during reset.
  - `oReq1_ready` equals `oReq0_ready`, but is 0 when `iReq0_valid`=1 or when the pending entry came from req0.
- Arbitration:
  - Fixed priority, req0 over req1, on simultaneous valid.
  - A later accept in HELD overwrites the pending entry (latest wins).
  - A tracker accept can never overwrite a host-pending entry within the same frame.
- Clamping (at accept, stored clamped):
  - x clamps to [BOX_HALF, H_ACT-1-BOX_HALF], i.e. [10, 629].
  - y clamps to [BOX_HALF, V_ACT-1-BOX_HALF], i.e. [10, 469].
  - Compare at full width with no wrap; inputs above the max saturate.
- Commit:
  - Coordinates load from pending; `oSrc` loads.
  - `oOverlay_en` goes to 1.
  - Timeout counter clears.
- Timeout:
  - The counter counts FEs without a commit and saturates at TIMEOUT_FRAMES.
  - When it reaches TIMEOUT_FRAMES, `oOverlay_en` goes to 0 in the cycle after that FE. Coordinates hold.
- Reset values:
  - `driven_coordinates_x`=320, `driven_coordinates_y`=240.
  - `oOverlay_en`=0, `oCommit`=0, `oSrc`=0.
  - Both readies 0; state IDLE; counter 0.
- Reset mid-operation: the pending entry is discarded and no commit occurs.

## Timing
- All outputs are registered.
- Ready is a function of state and `iReq0_valid` only; there is no combinational path from `iReq1_valid`.
- FE at cycle t causes `driven_coordinates_*`, `oSrc`, `oOverlay_en` and `oCommit` to update at t+1. The state is COMMIT at t+1.
- An accept at cycle t (not FE) is pending at t+1. It is committed at the first FE ≥ t+1.
- An accept on the FE cycle itself is committed at that FE.
- Worst-case request-to-effect latency: one frame plus 1 cycle.
- Ready is low for exactly 1 cycle per commit.

## Structure
- Shared package `overlay_pkg` holds:
  - `H_ACT`/`V_ACT` defaults and `BOX_HALF`.
  - `coord_x_t` (10 b) and `coord_y_t` (9 b).
  - The FSM enum `ovl_state_t` {IDLE, HELD, COMMIT}.
  - `src_t`.
- Sub-module `overlay_frame_sync` registers nothing. It combinationally produces the `fe` strobe from `iX_Cont`, `iY_Cont` and `iDVAL`, and is reusable by other frame-boundary consumers.
- The top level contains the arbiter, the clamp, the pending register, the FSM and the timeout counter.

## Test plan
- Reset release, then req0 (700, 500) accepted mid-frame → at FE+1: x=629, y=469, `oSrc`=0, `oCommit`=1 for 1 cycle, `oOverlay_en`=1.
- req0 (100, 50) and req1 (200, 60) valid in the same cycle → only `oReq0_ready` high. Then req1 retries in HELD: `oReq1_ready`=0 until COMMIT. Commit yields (100, 50).
- Two req1 accepts, (50, 40) then (60, 45), within one frame → commit (60, 45), `oSrc`=1. The coordinates do not change before FE.
- Accept on the exact FE cycle (x=639, y=479) → committed at t+1. Ready is 0 at t+1 and 1 at t+2.
- TIMEOUT_FRAMES=3, one commit, then 3 FEs with no requests → `oOverlay_en` drops at third FE+1 and the coordinates hold. A new request re-enables the overlay at the next FE+1.
- Assert `iRST` while HELD with (300, 200) pending, then release → outputs return to reset values and no `oCommit` occurs at the next FE.
